// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace debugger uDMA output buffer.
package trdb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    OVF   = 2'd2,
    DRAIN = 2'd3
  } trdb_buf_state_t;

  localparam logic [31:0] TRDB_OVF_MARKER  = 32'hFFFF_FFFF;
  localparam int          TRDB_DROPCNT_LEN = 16;

endpackage

// File: rtl/trdb_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers and a registered fill level.
module trdb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q, level_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop_ok  = pop && !empty;
  // a push into a full FIFO is only accepted when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level = level_q;

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full && !pop));

endmodule

// File: rtl/trdb_udma_buffer.sv
// Trace packet buffer towards the uDMA: absorbs a no-backpressure word stream,
// tracks drops, inserts an overflow marker on recovery and drains on flush.
module trdb_udma_buffer
  import trdb_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter int              THRESHOLD  = 8,
  parameter logic [XLEN-1:0] OVF_MARKER = XLEN'(TRDB_OVF_MARKER)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        flush_i,
  input  logic [XLEN-1:0]             word_i,
  input  logic                        word_valid_i,
  output logic [XLEN-1:0]             udma_data_o,
  output logic                        udma_valid_o,
  input  logic                        udma_ready_i,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  input  logic                        clear_overflow_i,
  output logic [TRDB_DROPCNT_LEN-1:0] drop_cnt_o,
  output logic                        irq_o,
  output logic                        done_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  typedef logic [LW:0] ext_t;
  localparam ext_t DEPTH_W = ext_t'(DEPTH);
  localparam ext_t THR_W   = ext_t'(THRESHOLD);
  localparam ext_t TWO_W   = ext_t'(2);

  trdb_buf_state_t             state_q, state_d;
  logic                        fifo_full, fifo_empty;
  logic                        pop, push, drop;
  logic [XLEN-1:0]             push_data;
  logic [LW-1:0]               level;
  ext_t                        free_slots, level_nxt;
  logic [TRDB_DROPCNT_LEN-1:0] drop_cnt_q;
  logic                        overflow_q, irq_q;

  function automatic logic [TRDB_DROPCNT_LEN-1:0] sat_inc(input logic [TRDB_DROPCNT_LEN-1:0] v);
    return (v == '1) ? v : v + TRDB_DROPCNT_LEN'(1);
  endfunction

  trdb_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (push_data),
    .rdata  (udma_data_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign udma_valid_o = !fifo_empty;
  assign pop          = udma_valid_o && udma_ready_i;
  // a pop in the same cycle frees a slot for the marker
  assign free_slots   = DEPTH_W - ext_t'(level) + ext_t'(pop);
  assign level_nxt    = ext_t'(level) + ext_t'(push) - ext_t'(pop);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    drop      = 1'b0;
    push_data = word_i;
    case (state_q)
      IDLE: begin
        if (enable_i && !flush_i) state_d = RUN;
      end
      RUN: begin
        if (word_valid_i) begin
          if (!fifo_full || pop) push = 1'b1;
          else                   drop = 1'b1;
        end
        if (flush_i)        state_d = DRAIN;
        else if (drop)      state_d = OVF;
        else if (!enable_i) state_d = IDLE;
      end
      OVF: begin
        drop = word_valid_i;
        if (flush_i)                  state_d = DRAIN;
        else if (!enable_i)           state_d = IDLE;
        else if (free_slots >= TWO_W) begin
          push      = 1'b1;
          push_data = OVF_MARKER;
          state_d   = RUN;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // a drop landing on the clear cycle survives as the first count of a new episode
      if (clear_overflow_i) begin
        drop_cnt_q <= TRDB_DROPCNT_LEN'(drop);
        overflow_q <= drop;
      end else if (drop) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
        overflow_q <= 1'b1;
      end
      irq_q <= (level_nxt >= THR_W) && (ext_t'(level) < THR_W);
    end
  end

  assign level_o    = level;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign irq_o      = irq_q;
  assign done_o     = (state_q == DRAIN) && fifo_empty;

endmodule
